// File: rtl/hazard3_uart_dtm_pkg.sv
// Shared definitions for the UART debug-transport receiver.
// Optional feature macro: HAZARD3_UART_DTM_RX_PARITY_EN (8E1 framing when defined).
package hazard3_uart_dtm_pkg;

    // Smallest usable bit period: below this there is no room to find the bit centre.
    localparam int UART_MIN_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

endpackage

// File: rtl/hazard3_sync_1bit.sv
// Single-bit metastability synchroniser; flops reset to 1 (idle line level).
module hazard3_sync_1bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '1;
        else        r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/hazard3_uart_dtm_rx.sv
// UART receiver for the debug transport: 8N1 by default, 8E1 when
// HAZARD3_UART_DTM_RX_PARITY_EN is defined. Received bytes sit in a
// single holding register offered to the downstream FIFO via wvld/wrdy.
module hazard3_uart_dtm_rx
    import hazard3_uart_dtm_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div,
    input  logic             rx,
    output logic [7:0]       wdata,
    output logic             wvld,
    input  logic             wrdy,
    output logic             err_framing,
    output logic             err_overflow,
    output logic             err_parity
);

    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(UART_MIN_DIV);

    logic             w_rxs;
    logic             r_rxs_prev;
    rx_state_e        r_state;
    rx_state_e        w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] w_div_clamp;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_wdata;
    logic             r_wvld;
    logic             r_err_fr;
    logic             r_err_ov;
    logic             w_cnt_zero;
    logic             w_start;
    logic             w_reload;
    logic             w_data_smp;
    logic             w_stop_smp;
    logic             w_par_ok;

    hazard3_sync_1bit #(.STAGES(SYNC_STAGES)) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx),
        .o_q   (w_rxs)
    );

    assign w_div_clamp = (div < MIN_DIV) ? MIN_DIV : div;
    assign w_cnt_zero  = (r_cnt == '0);

`ifdef HAZARD3_UART_DTM_RX_PARITY_EN
    logic w_par_smp;
    logic r_par_bad;
    logic r_err_par;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_reload    = 1'b0;
        w_data_smp  = 1'b0;
        w_stop_smp  = 1'b0;
`ifdef HAZARD3_UART_DTM_RX_PARITY_EN
        w_par_smp   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_rxs_prev && !w_rxs) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_cnt_zero) begin
                    if (w_rxs) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_reload    = 1'b1;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_cnt_zero) begin
                    w_data_smp = 1'b1;
                    w_reload   = 1'b1;
                    if (r_bitcnt == 3'd7) begin
`ifdef HAZARD3_UART_DTM_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef HAZARD3_UART_DTM_RX_PARITY_EN
            ST_PARITY: begin
                if (w_cnt_zero) begin
                    w_par_smp   = 1'b1;
                    w_reload    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_cnt_zero) begin
                    w_stop_smp  = 1'b1;
                    w_state_nxt = w_rxs ? ST_IDLE : ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rxs) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit-period counter. Reloading with period-1 at each sample makes
    // successive samples exactly one period apart; the start bit is found
    // at half a period (plus the one-cycle edge detect) from the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_period <= MIN_DIV;
        end else if (w_start) begin
            r_period <= w_div_clamp;
            r_cnt    <= w_div_clamp >> 1;
        end else if (w_reload) begin
            r_cnt    <= r_period - DIV_W'(1);
        end else if (!w_cnt_zero) begin
            r_cnt    <= r_cnt - DIV_W'(1);
        end
    end

    // Edge-detect history and LSB-first data shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxs_prev <= 1'b1;
            r_shift    <= '0;
            r_bitcnt   <= '0;
        end else begin
            r_rxs_prev <= w_rxs;
            if (w_start) begin
                r_bitcnt <= '0;
            end else if (w_data_smp) begin
                r_shift  <= {w_rxs, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

`ifdef HAZARD3_UART_DTM_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_par_bad <= 1'b0;
        else if (w_par_smp) r_par_bad <= w_rxs ^ (^r_shift);
    end

    assign w_par_ok = ~r_par_bad;

    // Parity error reported at the stop sample, whatever the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_par <= 1'b0;
        else        r_err_par <= w_stop_smp & r_par_bad;
    end

    assign err_parity = r_err_par;
`else
    assign w_par_ok   = 1'b1;
    assign err_parity = 1'b0;
`endif

    // Holding register, handshake and error pulses. A frame completing in
    // the same cycle the old byte is accepted replaces it without overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdata  <= '0;
            r_wvld   <= 1'b0;
            r_err_fr <= 1'b0;
            r_err_ov <= 1'b0;
        end else begin
            r_err_fr <= 1'b0;
            r_err_ov <= 1'b0;
            if (r_wvld && wrdy) r_wvld <= 1'b0;
            if (w_stop_smp) begin
                if (!w_rxs) begin
                    r_err_fr <= 1'b1;
                end else if (w_par_ok) begin
                    if (r_wvld && !wrdy) begin
                        r_err_ov <= 1'b1;
                    end else begin
                        r_wdata <= r_shift;
                        r_wvld  <= 1'b1;
                    end
                end
            end
        end
    end

    assign wdata        = r_wdata;
    assign wvld         = r_wvld;
    assign err_framing  = r_err_fr;
    assign err_overflow = r_err_ov;

endmodule

// File: tb/tb_hazard3_uart_dtm_rx.sv
// Self-checking bench for hazard3_uart_dtm_rx: frames are generated from
// byte values and line-level rules; expected bytes and error pulses are
// queued per frame and matched by an independent output monitor.
module tb_hazard3_uart_dtm_rx;

    localparam int DIV_W = 16;
`ifdef HAZARD3_UART_DTM_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum int { E_FR = 1, E_OV = 2, E_PAR = 3 } err_e;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DIV_W-1:0] div = 16'd16;
    logic             rx = 1'b1;
    logic [7:0]       wdata;
    logic             wvld;
    logic             wrdy = 1'b1;
    logic             err_framing;
    logic             err_overflow;
    logic             err_parity;

    always #5 clk = ~clk;

    hazard3_uart_dtm_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div          (div),
        .rx           (rx),
        .wdata        (wdata),
        .wvld         (wvld),
        .wrdy         (wrdy),
        .err_framing  (err_framing),
        .err_overflow (err_overflow),
        .err_parity   (err_parity)
    );

    logic [7:0] q_byte[$];
    err_e       q_err[$];
    int         n_err = 0;
    int         n_chk = 0;
    bit         m_hold_full = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: outcome of one frame from its line-level content.
    task automatic model_frame(input logic [7:0] d, input bit stop, input bit par);
        bit par_ok;
        par_ok = !PAR_EN || (par == ^d);
        if (!stop)   q_err.push_back(E_FR);
        if (!par_ok) q_err.push_back(E_PAR);
        if (stop && par_ok) begin
            if (m_hold_full) q_err.push_back(E_OV);
            else begin
                q_byte.push_back(d);
                m_hold_full = !wrdy;
            end
        end
    endtask

    // Drive one frame; optionally change div mid-frame or hold the line low
    // after a bad stop bit for a number of bit times.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par,
                              input int mid_div, input int low_bits);
        int p;
        p = (int'(div) < 4) ? 4 : int'(div);
        model_frame(d, stop, par);
        rx = 1'b0;
        tick(p);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(p);
            if (i == 2 && mid_div >= 0) div = DIV_W'(mid_div);
        end
        if (PAR_EN) begin
            rx = par;
            tick(p);
        end
        rx = stop;
        tick(p);
        if (!stop && low_bits > 0) tick(low_bits * p);
        rx = 1'b1;
        tick(2 * p + 4);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b1, ^d, -1, 0);
    endtask

    // Output monitor, sampling on the falling edge.
    logic       pv_vld = 1'b0, pv_rdy = 1'b0, pv_fr = 1'b0, pv_ov = 1'b0, pv_par = 1'b0;
    logic [7:0] pv_data = 8'h00;

    task automatic pop_err(input err_e kind);
        if (q_err.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL err_unexpected: got kind %0d expected none (t=%0t)", int'(kind), $time);
        end else begin
            check("err_kind", int'(kind), int'(q_err.pop_front()));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_vld = 1'b0; pv_rdy = 1'b0; pv_fr = 1'b0; pv_ov = 1'b0; pv_par = 1'b0;
        end else begin
            if (pv_vld && !pv_rdy) begin
                check("hold_wvld", wvld, 1'b1);
                check("hold_wdata", wdata, pv_data);
            end
            if (pv_vld && pv_rdy) check("wvld_drop", wvld, 1'b0);
            if (pv_fr)  check("framing_pulse_width", err_framing, 1'b0);
            if (pv_ov)  check("overflow_pulse_width", err_overflow, 1'b0);
            if (pv_par) check("parity_pulse_width", err_parity, 1'b0);
            if (err_framing)  pop_err(E_FR);
            if (err_overflow) pop_err(E_OV);
            if (err_parity)   pop_err(E_PAR);
            if (wvld && wrdy) begin
                if (q_byte.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL byte_unexpected: got %0h expected none (t=%0t)", wdata, $time);
                end else begin
                    check("byte_data", wdata, q_byte.pop_front());
                end
            end
            pv_vld = wvld; pv_rdy = wrdy; pv_data = wdata;
            pv_fr = err_framing; pv_ov = err_overflow; pv_par = err_parity;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit         stop;
        bit         par;

        // Reset state.
        tick(3);
        check("rst_wvld", wvld, 1'b0);
        check("rst_wdata", wdata, 8'h00);
        check("rst_err_framing", err_framing, 1'b0);
        check("rst_err_overflow", err_overflow, 1'b0);
        check("rst_err_parity", err_parity, 1'b0);
        rst_n = 1'b1;
        tick(5);

        // Basic frame.
        div = 16'd16;
        send_good(8'hA5);

        // Short low glitch: rejected at the start-bit centre.
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(40);

        // Bad stop bit followed by a long break, then a normal frame.
        send_frame(8'h3C, 1'b0, ^8'h3C, -1, 40);
        send_good(8'h55);

        // Overflow: second byte dropped while the first is held.
        wrdy = 1'b0;
        send_good(8'h11);
        send_good(8'h22);
        check("ovf_wvld", wvld, 1'b1);
        check("ovf_wdata", wdata, 8'h11);
        wrdy = 1'b1;
        m_hold_full = 1'b0;
        tick(4);
        check("ovf_accepted", wvld, 1'b0);

        // Parity bit wrong then right (in 8N1 the parity argument is not sent).
        send_frame(8'h07, 1'b1, 1'b0, -1, 0);
        send_frame(8'h07, 1'b1, 1'b1, -1, 0);

        // Divisor clamping and odd divisor.
        div = 16'd2;
        send_good(8'hF0);
        div = 16'd5;
        send_good(8'hF0);

        // div changed mid-frame must only affect the next frame.
        div = 16'd16;
        send_frame(8'h9C, 1'b1, ^8'h9C, 6, 0);
        send_good(8'h3A);

        // Reset in the middle of a frame discards it.
        div = 16'd16;
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
        tick(20);
        rst_n = 1'b0;
        tick(2);
        check("midrst_wvld", wvld, 1'b0);
        check("midrst_err_framing", err_framing, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(300);
        send_good(8'hC3);

        // Randomised frames.
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            div  = DIV_W'($urandom_range(0, 20));
            stop = ($urandom_range(0, 7) != 0);
            par  = (^d) ^ ($urandom_range(0, 7) == 0);
            send_frame(d, stop, par, -1, 0);
        end

        tick(100);
        check("byte_queue_empty", q_byte.size(), 0);
        check("err_queue_empty", q_err.size(), 0);
        check("final_wvld", wvld, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
